// File: rtl/pin_pulser.sv
// Timed pulse-burst driver for an output pin.
// Emits N on/off pulses per accepted start, then a one-cycle done.
module pin_pulser #(
  parameter bit          ACTIVE   = 1'b1,
  parameter logic [31:0] ON_TIME  = 32'd2000000,
  parameter logic [31:0] OFF_TIME = 32'd2000000,
  parameter int          COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               pin
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t             state, state_d;
  logic [31:0]        timer, timer_d;
  logic [COUNT_W-1:0] remaining, remaining_d;
  logic               pin_d, busy_d, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= '0;
      pin       <= ~ACTIVE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      remaining <= remaining_d;
      pin       <= pin_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    remaining_d = remaining;
    pin_d       = pin;
    busy_d      = busy;
    done_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d     = ON;
            pin_d       = ACTIVE;
            busy_d      = 1'b1;
            remaining_d = count;
            timer_d     = ON_TIME - 32'd1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ON: begin
        if (timer != '0) begin
          timer_d = timer - 32'd1;
        end else begin
          state_d     = OFF;
          pin_d       = ~ACTIVE;
          timer_d     = OFF_TIME - 32'd1;
          remaining_d = remaining - ONE;
        end
      end
      OFF: begin
        // the trailing gap always runs in full before idling
        if (timer != '0) begin
          timer_d = timer - 32'd1;
        end else if (remaining != '0) begin
          state_d = ON;
          pin_d   = ACTIVE;
          timer_d = ON_TIME - 32'd1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = ~ACTIVE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pin_pulser.sv
// Randomised and directed checks of pin_pulser.
// Active-high and active-low instances share stimulus.
module tb_pin_pulser;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] count = 8'd0;
  logic       busy, done, pin;
  logic       busy_b, done_b, pin_b;
  logic [5:0] obs;

  int total = 0;
  int passed = 0;

  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_pos = 0;
  int m_n = 0;

  always #5 clk = ~clk;

  pin_pulser #(
    .ACTIVE(1'b1), .ON_TIME(32'd3),
    .OFF_TIME(32'd2), .COUNT_W(8)
  ) dut_h (
    .clk(clk), .reset(reset), .start(start),
    .count(count), .busy(busy), .done(done),
    .pin(pin)
  );

  pin_pulser #(
    .ACTIVE(1'b0), .ON_TIME(32'd3),
    .OFF_TIME(32'd2), .COUNT_W(8)
  ) dut_l (
    .clk(clk), .reset(reset), .start(start),
    .count(count), .busy(busy_b), .done(done_b),
    .pin(pin_b)
  );

  assign obs = {busy, done, pin, busy_b, done_b, pin_b};

  // burst position arithmetic: pulse i on for pos in [i*P, i*P+ON)
  function automatic logic [5:0] exp_vec();
    logic p;
    p = m_busy && ((m_pos % P) < ON);
    return {m_busy, m_done, p, m_busy, m_done, ~p};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_done = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_pos++;
      if (m_pos == m_n * P) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (start) begin
      if (count == 8'd0) begin
        m_done = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_pos = 0;
        m_n = int'(count);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 6'b000_001)
      $display("FAIL reset_state got=%b exp=%b", obs, 6'b000_001);
    else passed++;
    reset = 1'b0;
    tick();
    total++;
    if (obs !== exp_vec())
      $display("FAIL reset_idle got=%b exp=%b", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_basic();
    logic [11:0] pat;
    int busy_cnt, done_at;
    pat = 12'b0000_1110_0111;
    busy_cnt = 0;
    done_at = -1;
    start = 1'b1;
    count = 8'd2;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      total++;
      if (obs !== exp_vec())
        $display("FAIL basic c=%0d got=%b exp=%b", c, obs, exp_vec());
      else passed++;
      total++;
      if (pin !== pat[c-1])
        $display("FAIL basic_pin c=%0d got=%b exp=%b", c, pin, pat[c-1]);
      else passed++;
      if (busy) busy_cnt++;
      if (done) done_at = c;
      tick();
    end
    total++;
    if (busy_cnt != 10)
      $display("FAIL basic_busy got=%0d exp=10", busy_cnt);
    else passed++;
    total++;
    if (done_at != 11)
      $display("FAIL basic_done got=%0d exp=11", done_at);
    else passed++;
  endtask

  task automatic test_zero_count();
    int dn;
    dn = 0;
    start = 1'b1;
    count = 8'd0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (obs !== exp_vec())
        $display("FAIL zero c=%0d got=%b exp=%b", c, obs, exp_vec());
      else passed++;
      if (done) dn++;
      tick();
    end
    total++;
    if (dn != 1)
      $display("FAIL zero_done got=%0d exp=1", dn);
    else passed++;
  endtask

  task automatic test_restart_ignored();
    int rises, dn, gaps;
    logic prev;
    rises = 0; dn = 0; gaps = 0; prev = 1'b0;
    start = 1'b1;
    count = 8'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      total++;
      if (obs !== exp_vec())
        $display("FAIL restart c=%0d got=%b exp=%b", c, obs, exp_vec());
      else passed++;
      if (pin && !prev) rises++;
      prev = pin;
      if (done) dn++;
      if (c <= 15 && !busy) gaps++;
      start = (c == 4);
      count = (c == 4) ? 8'd7 : 8'd0;
      tick();
    end
    total++;
    if (rises != 3 || dn != 1 || gaps != 0)
      $display("FAIL restart_counts got=%0d/%0d/%0d exp=3/1/0",
               rises, dn, gaps);
    else passed++;
  endtask

  task automatic test_held_start();
    int run;
    run = 0;
    start = 1'b1;
    count = 8'd1;
    for (int c = 0; c < 30; c++) begin
      tick();
      total++;
      if (obs !== exp_vec())
        $display("FAIL held c=%0d got=%b exp=%b", c, obs, exp_vec());
      else passed++;
      if (pin) begin
        run++;
      end else if (run != 0) begin
        total++;
        if (run != ON)
          $display("FAIL held_run got=%0d exp=%0d", run, ON);
        else passed++;
        run = 0;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    total++;
    if (obs !== exp_vec() || busy !== 1'b0)
      $display("FAIL held_end got=%b exp=%b", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    count = 8'd2;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (obs !== 6'b000_001)
      $display("FAIL mid_reset got=%b exp=%b", obs, 6'b000_001);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (obs !== exp_vec() || done !== 1'b0)
        $display("FAIL mid_quiet got=%b exp=%b", obs, exp_vec());
      else passed++;
    end
    start = 1'b1;
    count = 8'd2;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      total++;
      if (obs !== exp_vec())
        $display("FAIL mid_again c=%0d got=%b exp=%b", c, obs, exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_max_count();
    int rises;
    logic prev;
    rises = 0;
    prev = 1'b0;
    start = 1'b1;
    count = 8'd255;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 255 * P + 3; c++) begin
      total++;
      if (obs !== exp_vec())
        $display("FAIL max c=%0d got=%b exp=%b", c, obs, exp_vec());
      else passed++;
      if (pin && !prev) rises++;
      prev = pin;
      tick();
    end
    total++;
    if (rises != 255)
      $display("FAIL max_pulses got=%0d exp=255", rises);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom % 4) == 0;
      count = 8'($urandom_range(0, 3));
      reset = ($urandom % 97) == 0;
      tick();
      total++;
      if (obs !== exp_vec())
        $display("FAIL random c=%0d got=%b exp=%b", c, obs, exp_vec());
      else passed++;
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_restart_ignored();
    test_held_start();
    test_reset_mid();
    test_max_count();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
